// File: rtl/counter_bank_pkg.sv
// Shared types and helpers for the parametrised event-counter bank.
// Imported by the counter cells and by the bank top level.
package counter_bank_pkg;

    typedef enum logic {
        MODE_WRAP     = 1'b0,
        MODE_SATURATE = 1'b1
    } mode_e;

    typedef enum logic {
        IDLE    = 1'b0,
        READOUT = 1'b1
    } state_e;

    // A single-channel bank still needs a one-bit channel index.
    function automatic int unsigned chan_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/counter_cell.sv
// One event counter with a sticky overflow flag.
// Clear has priority over increment; overflow either wraps or saturates.
module counter_cell
    import counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter mode_e       MODE       = MODE_WRAP,
    parameter logic [31:0] INIT_VALUE = 32'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] INIT = INIT_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    // NOTE: state registers use non-blocking assignments so every cell
    // samples the same pre-edge values, regardless of process order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= INIT;
            ovf   <= 1'b0;
        end else if (clear) begin
            count <= INIT;
            ovf   <= 1'b0;
        end else if (inc) begin
            if (count == ALL_ONES) begin
                ovf   <= 1'b1;
                count <= (MODE == MODE_SATURATE) ? ALL_ONES : '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_counter_bank.sv
// Multi-channel event-counter bank with a snapshot-and-stream readout.
// Shadow registers freeze all counters at snap_start; beats stream out under rd_valid/rd_ready.
module param_counter_bank
    import counter_bank_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS   = 4,
    parameter int unsigned WIDTH          = 8,
    parameter mode_e       MODE           = MODE_WRAP,
    parameter logic [31:0] INIT_VALUE     = 32'd0,
    parameter bit          SOME_BIT_PARAM = 1'b1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_CHANNELS-1:0]              inc,
    input  logic [NUM_CHANNELS-1:0]              clear,
    input  logic                                 snap_start,
    output logic                                 snap_busy,
    output logic                                 snap_done,
    output logic                                 rd_valid,
    input  logic                                 rd_ready,
    output logic [chan_idx_w(NUM_CHANNELS)-1:0]  rd_chan,
    output logic [WIDTH-1:0]                     rd_data,
    output logic                                 rd_ovf,
    output logic [NUM_CHANNELS-1:0]              ovf
);

    localparam int unsigned IDX_W = chan_idx_w(NUM_CHANNELS);

    logic [WIDTH-1:0] count [NUM_CHANNELS];

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_cell
        counter_cell #(
            .WIDTH      (WIDTH),
            .MODE       (MODE),
            .INIT_VALUE (INIT_VALUE)
        ) u_cell (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[i]),
            .clear (clear[i]),
            .count (count[i]),
            .ovf   (ovf[i])
        );
    end

    if (SOME_BIT_PARAM) begin : g_snap
        localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNELS - 1);

        state_e                  state_q, state_d;
        logic [IDX_W-1:0]        idx_q, idx_d;
        logic                    done_q, done_d;
        logic                    capture;
        logic [WIDTH-1:0]        shadow_cnt [NUM_CHANNELS];
        logic [NUM_CHANNELS-1:0] shadow_ovf;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= IDLE;
                idx_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                idx_q   <= idx_d;
                done_q  <= done_d;
            end
        end

        // NOTE: the shadow array is deliberately not reset; it is only
        // observable while READOUT, which always starts with a fresh capture.
        always_ff @(posedge clk) begin
            if (capture) begin
                shadow_cnt <= count;
                shadow_ovf <= ovf;
            end
        end

        always_comb begin
            state_d = state_q;
            idx_d   = idx_q;
            done_d  = 1'b0;
            capture = 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (snap_start) begin
                        capture = 1'b1;
                        state_d = READOUT;
                        idx_d   = '0;
                    end
                end
                READOUT: begin
                    if (rd_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = IDLE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Readout outputs are gated so they read as zero outside READOUT.
        assign rd_valid  = (state_q == READOUT);
        assign snap_busy = rd_valid;
        assign snap_done = done_q;
        assign rd_chan   = rd_valid ? idx_q : '0;
        assign rd_data   = rd_valid ? shadow_cnt[idx_q] : '0;
        assign rd_ovf    = rd_valid & shadow_ovf[idx_q];
    end else begin : g_no_snap
        assign rd_valid  = 1'b0;
        assign snap_busy = 1'b0;
        assign snap_done = 1'b0;
        assign rd_chan   = '0;
        assign rd_data   = '0;
        assign rd_ovf    = 1'b0;
    end

endmodule

// File: tb/tb_param_counter_bank.sv
// Bench for param_counter_bank: three instances (8-bit wrap, 4-bit wrap, 4-bit saturate)
// share stimulus and are compared every cycle against an arithmetic reference model.
module tb_param_counter_bank;
    import counter_bank_pkg::*;

    localparam int NB = 3;
    localparam int NC = 4;

    logic          clk;
    logic          rst_n;
    logic [NC-1:0] inc;
    logic [NC-1:0] clear;
    logic          snap_start;
    logic          rd_ready;

    logic          sb [NB];
    logic          sd [NB];
    logic          rv [NB];
    logic          ro [NB];
    logic [1:0]    rc [NB];
    logic [NC-1:0] ov [NB];
    logic [7:0]    d0;
    logic [3:0]    d1, d2;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int unsigned m_cnt [NB][NC];
    bit          m_ovf [NB][NC];
    int unsigned m_shc [NB][NC];
    bit          m_sho [NB][NC];
    bit          m_busy;
    int unsigned m_idx;
    bit          m_done;
    int unsigned got [NB][NC];

    param_counter_bank #(.NUM_CHANNELS(NC), .WIDTH(8), .MODE(MODE_WRAP)) dut0 (
        .clk(clk), .rst_n(rst_n), .inc(inc), .clear(clear), .snap_start(snap_start),
        .snap_busy(sb[0]), .snap_done(sd[0]), .rd_valid(rv[0]), .rd_ready(rd_ready),
        .rd_chan(rc[0]), .rd_data(d0), .rd_ovf(ro[0]), .ovf(ov[0]));

    param_counter_bank #(.NUM_CHANNELS(NC), .WIDTH(4), .MODE(MODE_WRAP)) dut1 (
        .clk(clk), .rst_n(rst_n), .inc(inc), .clear(clear), .snap_start(snap_start),
        .snap_busy(sb[1]), .snap_done(sd[1]), .rd_valid(rv[1]), .rd_ready(rd_ready),
        .rd_chan(rc[1]), .rd_data(d1), .rd_ovf(ro[1]), .ovf(ov[1]));

    param_counter_bank #(.NUM_CHANNELS(NC), .WIDTH(4), .MODE(MODE_SATURATE)) dut2 (
        .clk(clk), .rst_n(rst_n), .inc(inc), .clear(clear), .snap_start(snap_start),
        .snap_busy(sb[2]), .snap_done(sd[2]), .rd_valid(rv[2]), .rd_ready(rd_ready),
        .rd_chan(rc[2]), .rd_data(d2), .rd_ovf(ro[2]), .ovf(ov[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned max_val(input int b);
        return (b == 0) ? 255 : 15;
    endfunction

    function automatic logic [31:0] data_of(input int b);
        case (b)
            0:       return 32'(d0);
            1:       return 32'(d1);
            default: return 32'(d2);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies the inputs present at this edge to the model.
    task automatic model_step();
        if (!rst_n) begin
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < NC; i++) begin
                    m_cnt[b][i] = 0;
                    m_ovf[b][i] = 1'b0;
                end
            m_busy = 1'b0;
            m_idx  = 0;
            m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (snap_start) begin
                    m_busy = 1'b1;
                    m_idx  = 0;
                    m_shc  = m_cnt;
                    m_sho  = m_ovf;
                end
            end else if (rd_ready) begin
                if (m_idx == NC - 1) begin
                    m_busy = 1'b0;
                    m_idx  = 0;
                    m_done = 1'b1;
                end else begin
                    m_idx++;
                end
            end
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < NC; i++) begin
                    if (clear[i]) begin
                        m_cnt[b][i] = 0;
                        m_ovf[b][i] = 1'b0;
                    end else if (inc[i]) begin
                        if (m_cnt[b][i] + 1 > max_val(b)) begin
                            m_ovf[b][i] = 1'b1;
                            m_cnt[b][i] = (b == 2) ? max_val(b) : 0;
                        end else begin
                            m_cnt[b][i]++;
                        end
                    end
                end
        end
    endtask

    task automatic compare_all();
        for (int b = 0; b < NB; b++) begin
            logic [NC-1:0] exp_ovf;
            for (int i = 0; i < NC; i++) exp_ovf[i] = m_ovf[b][i];
            check($sformatf("b%0d_ovf", b), 32'(ov[b]), 32'(exp_ovf));
            check($sformatf("b%0d_snap_busy", b), 32'(sb[b]), 32'(m_busy));
            check($sformatf("b%0d_snap_done", b), 32'(sd[b]), 32'(m_done));
            check($sformatf("b%0d_rd_valid", b), 32'(rv[b]), 32'(m_busy));
            check($sformatf("b%0d_rd_chan", b), 32'(rc[b]), m_busy ? m_idx : 0);
            check($sformatf("b%0d_rd_data", b), data_of(b), m_busy ? m_shc[b][m_idx] : 0);
            check($sformatf("b%0d_rd_ovf", b), 32'(ro[b]), m_busy ? 32'(m_sho[b][m_idx]) : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Full snapshot with rd_ready high; every transferred beat lands in got[][].
    task automatic do_snapshot();
        for (int b = 0; b < NB; b++)
            for (int i = 0; i < NC; i++) got[b][i] = 32'hdead;
        snap_start = 1'b1;
        rd_ready   = 1'b1;
        tick();
        snap_start = 1'b0;
        for (int k = 0; k < 20 && rv[0]; k++) begin
            for (int b = 0; b < NB; b++)
                if (rv[b]) got[b][rc[b]] = data_of(b);
            tick();
        end
        if (rv[0]) check("snap_timeout", 32'(sb[0]), 32'd0);
    endtask

    task automatic run_inc(input logic [NC-1:0] pattern, input int n);
        inc = pattern;
        repeat (n) tick();
        inc = '0;
    endtask

    initial begin
        rst_n      = 1'b0;
        inc        = '0;
        clear      = '0;
        snap_start = 1'b0;
        rd_ready   = 1'b0;

        // Reset state and five increments on channel 2
        do_reset();
        check("reset_ovf", 32'(ov[0]), 32'd0);
        run_inc(4'b0100, 5);
        check("five_ovf", 32'(ov[0]), 32'd0);
        do_snapshot();
        check("five_ch2", got[0][2], 32'd5);
        check("five_ch0", got[0][0], 32'd0);
        check("five_ch3", got[0][3], 32'd0);

        // 17 increments on channel 0: 4-bit wrap ends at 1 with overflow
        do_reset();
        run_inc(4'b0001, 17);
        check("wrap_ovf_w4", 32'(ov[1][0]), 32'd1);
        check("wrap_ovf_w8", 32'(ov[0][0]), 32'd0);
        do_snapshot();
        check("wrap_val_w4", got[1][0], 32'd1);
        check("wrap_val_w8", got[0][0], 32'd17);
        clear = 4'b0001;
        tick();
        clear = '0;
        check("clear_ovf_w4", 32'(ov[1][0]), 32'd0);
        do_snapshot();
        check("clear_val_w4", got[1][0], 32'd0);

        // 20 increments on channel 1: saturate holds 15
        do_reset();
        run_inc(4'b0010, 20);
        check("sat_ovf", 32'(ov[2][1]), 32'd1);
        do_snapshot();
        check("sat_val", got[2][1], 32'd15);
        check("wrap20_val", got[1][1], 32'd4);
        run_inc(4'b0010, 3);
        do_snapshot();
        check("sat_hold", got[2][1], 32'd15);

        // Counters {3,0,7,1} streamed back-to-back
        do_reset();
        for (int k = 0; k < 7; k++) begin
            inc = {k < 1, 1'b1, 1'b0, k < 3};
            tick();
        end
        inc = '0;
        do_snapshot();
        check("stream_done", 32'(sd[0]), 32'd1);
        check("stream_b0", got[0][0], 32'd3);
        check("stream_b1", got[0][1], 32'd0);
        check("stream_b2", got[0][2], 32'd7);
        check("stream_b3", got[0][3], 32'd1);
        tick();
        check("done_pulse_end", 32'(sd[0]), 32'd0);

        // Backpressure on beat 1 while all channels count; snap_start ignored while busy
        snap_start = 1'b1;
        rd_ready   = 1'b1;
        tick();
        snap_start = 1'b0;
        tick();
        rd_ready   = 1'b0;
        inc        = 4'b1111;
        snap_start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_chan", 32'(rc[0]), 32'd1);
            check("stall_data", 32'(d0), 32'd0);
        end
        inc        = '0;
        snap_start = 1'b0;
        rd_ready   = 1'b1;
        for (int k = 0; k < 10 && rv[0]; k++) tick();
        check("stall_idle", 32'(sb[0]), 32'd0);
        do_snapshot();
        check("live_c0", got[0][0], 32'd6);
        check("live_c1", got[0][1], 32'd3);
        check("live_c2", got[0][2], 32'd10);
        check("live_c3", got[0][3], 32'd4);

        // Reset during beat 2 aborts the readout without snap_done
        snap_start = 1'b1;
        tick();
        snap_start = 1'b0;
        tick();
        tick();
        check("abort_beat", 32'(rc[0]), 32'd2);
        rst_n = 1'b0;
        tick();
        check("abort_valid", 32'(rv[0]), 32'd0);
        check("abort_busy", 32'(sb[0]), 32'd0);
        check("abort_done", 32'(sd[0]), 32'd0);
        rst_n = 1'b1;
        tick();
        check("abort_no_done", 32'(sd[0]), 32'd0);
        do_snapshot();
        check("abort_init_c0", got[0][0], 32'd0);
        check("abort_init_c2", got[0][2], 32'd0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            inc        = NC'($urandom);
            clear      = ($urandom_range(0, 11) == 0) ? NC'($urandom) : '0;
            snap_start = ($urandom_range(0, 5) == 0);
            rd_ready   = ($urandom_range(0, 2) != 0);
            rst_n      = ($urandom_range(0, 149) != 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
